// File: rtl/rp_sd_arb.sv
// rp_sd_arb: round-robin arbiter granting one of eight RP drives access to
// the shared SD controller. The granted drive's operation and sector address
// are latched at grant time. A watchdog forces completion if the controller
// never acknowledges.
module rp_sd_arb #(
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [7:0]   rpSDREQ,
    input  logic [23:0]  rpSDOPV,
    input  logic [167:0] rpSDLSAV,
    output logic [7:0]   rpSDACK,
    output logic         sdREQ,
    input  logic         sdACK,
    output logic [2:0]   sdOP,
    output logic [20:0]  sdLSA,
    output logic [2:0]   sdSCAN,
    output logic         arbBUSY,
    output logic         arbTO
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_DROP
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   last_q,  last_d;
    logic [23:0]  wdog_q,  wdog_d;
    logic [2:0]   scan_q,  scan_d;
    logic [2:0]   op_q,    op_d;
    logic [20:0]  lsa_q,   lsa_d;

    logic [2:0]   pick;
    logic         pick_vld;
    logic [2:0]   cand;
    logic [2:0]   pick_op;
    logic [20:0]  pick_lsa;
    logic         wdog_exp;

    // Round-robin search starting one past the last granted drive; the 8th
    // candidate wraps back onto the last drive itself.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            cand = last_q + 3'(k);
            if (!pick_vld && rpSDREQ[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Select the operation and sector-address slices of the candidate drive.
    always_comb begin
        pick_op  = '0;
        pick_lsa = '0;
        for (int unsigned d = 0; d < 8; d++) begin
            if (pick == 3'(d)) begin
                pick_op  = rpSDOPV[3*d +: 3];
                pick_lsa = rpSDLSAV[21*d +: 21];
            end
        end
    end

    assign wdog_exp = (TIMEOUT != '0) && (wdog_q == TIMEOUT - 24'd1);

    // Next-state logic: clr overrides every transition, latched grant data
    // changes only on a new grant.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        scan_d  = scan_q;
        op_d    = op_q;
        lsa_d   = lsa_q;
        if (clr) begin
            state_d = ST_IDLE;
            last_d  = 3'd7;
            wdog_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        scan_d  = pick;
                        op_d    = pick_op;
                        lsa_d   = pick_lsa;
                        last_d  = pick;
                        wdog_d  = '0;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A drive dropping its request here does not abort the
                    // transfer; only sdACK or the watchdog leave this state.
                    if (sdACK || wdog_exp) begin
                        state_d = ST_ACK;
                    end else begin
                        wdog_d = wdog_q + 24'd1;
                    end
                end
                ST_ACK: begin
                    state_d = ST_DROP;
                end
                ST_DROP: begin
                    if (!rpSDREQ[scan_q]) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and latched-grant registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= 3'd7;
            wdog_q  <= '0;
            scan_q  <= '0;
            op_q    <= '0;
            lsa_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            scan_q  <= scan_d;
            op_q    <= op_d;
            lsa_q   <= lsa_d;
        end
    end

    // Outputs decoded from the current state; arbTO is suppressed whenever
    // sdACK, clr or reset wins the same cycle so it never pulses without the
    // watchdog-driven ACK transition actually taking place.
    always_comb begin
        sdREQ   = (state_q == ST_REQ);
        arbBUSY = (state_q != ST_IDLE);
        rpSDACK = (state_q == ST_ACK) ? (8'd1 << scan_q) : '0;
        arbTO   = rst && !clr && (state_q == ST_REQ) && !sdACK && wdog_exp;
        sdOP    = op_q;
        sdLSA   = lsa_q;
        sdSCAN  = scan_q;
    end

endmodule

// File: tb/tb_rp_sd_arb.sv
// Testbench for rp_sd_arb: randomized stimulus checked against a
// transaction-level reference model of the arbitration rules.
module tb_rp_sd_arb;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [7:0]   rpSDREQ;
    logic [23:0]  rpSDOPV;
    logic [167:0] rpSDLSAV;
    logic [7:0]   rpSDACK;
    logic         sdREQ;
    logic         sdACK;
    logic [2:0]   sdOP;
    logic [20:0]  sdLSA;
    logic [2:0]   sdSCAN;
    logic         arbBUSY;
    logic         arbTO;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rp_sd_arb #(.TIMEOUT(24'(TO))) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .rpSDREQ  (rpSDREQ),
        .rpSDOPV  (rpSDOPV),
        .rpSDLSAV (rpSDLSAV),
        .rpSDACK  (rpSDACK),
        .sdREQ    (sdREQ),
        .sdACK    (sdACK),
        .sdOP     (sdOP),
        .sdLSA    (sdLSA),
        .sdSCAN   (sdSCAN),
        .arbBUSY  (arbBUSY),
        .arbTO    (arbTO)
    );

    // Reference model: phase 0 idle, 1 waiting on controller, 2 completing,
    // 3 waiting for the drive to release its request.
    int          m_ph, m_last, m_cnt, m_scan, m_d;
    logic        m_found;
    logic [2:0]  m_op;
    logic [20:0] m_lsa;
    int          grants[$];

    always @(posedge clk) begin
        if (!rst) begin
            m_ph = 0; m_last = 7; m_cnt = 0; m_scan = 0; m_op = '0; m_lsa = '0;
        end else if (clr) begin
            m_ph = 0; m_last = 7; m_cnt = 0;
        end else begin
            case (m_ph)
                0: if (rpSDREQ != 8'h00) begin
                    m_found = 1'b0;
                    for (int k = 1; k <= 8; k++) begin
                        m_d = (m_last + k) % 8;
                        if (!m_found && rpSDREQ[m_d]) begin
                            m_scan = m_d;
                            m_found = 1'b1;
                        end
                    end
                    m_op = rpSDOPV[3*m_scan +: 3];
                    m_lsa = rpSDLSAV[21*m_scan +: 21];
                    m_last = m_scan;
                    m_cnt = 0;
                    m_ph = 1;
                    grants.push_back(m_scan);
                end
                1: begin
                    if (sdACK || m_cnt == TO - 1) m_ph = 2;
                    else m_cnt++;
                end
                2: m_ph = 3;
                default: if (!rpSDREQ[m_scan]) m_ph = 0;
            endcase
        end
    end

    function automatic logic [37:0] m_out();
        logic [7:0] a;
        a = (m_ph == 2) ? 8'(1 << m_scan) : 8'h00;
        return {a, (m_ph == 1), m_op, m_lsa, 3'(m_scan), (m_ph != 0),
                (m_ph == 1 && m_cnt == TO - 1 && !sdACK && !clr && rst)};
    endfunction

    function automatic logic [37:0] dut_out();
        return {rpSDACK, sdREQ, sdOP, sdLSA, sdSCAN, arbBUSY, arbTO};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_slices();
        for (int d = 0; d < 8; d++) begin
            rpSDOPV[3*d +: 3]   = 3'($urandom);
            rpSDLSAV[21*d +: 21] = 21'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; clr = 1'b0; rpSDREQ = '0; sdACK = 1'b0;
        rand_slices();
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [37:0] obs;
        rand_slices();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rpSDREQ = 8'($urandom); sdACK = 1'($urandom); clr = 1'($urandom);
            tick(); #2;
            obs = dut_out();
            checks++;
            if (obs !== 38'h0) begin
                errors++; $display("FAIL reset: got %h expected %h", obs, 38'h0);
            end
        end
        rst = 1'b1; clr = 1'b0; rpSDREQ = '0; sdACK = 1'b0;
    endtask

    task automatic test_single();
        logic [27:0] g;
        do_reset();
        rpSDOPV[8:6] = 3'd1;
        rpSDLSAV[62:42] = 21'h00ABCD;
        rpSDREQ = 8'h04;
        tick(); #2;
        g = {sdREQ, sdSCAN, sdOP, sdLSA};
        checks++;
        if (g !== {1'b1, 3'd2, 3'd1, 21'h00ABCD}) begin
            errors++; $display("FAIL single_grant: got %h expected %h", g, {1'b1, 3'd2, 3'd1, 21'h00ABCD});
        end
        rpSDOPV[8:6] = 3'd5; rpSDLSAV[62:42] = 21'h1F0000; rpSDREQ = 8'h00;
        tick(); #2;
        checks++;
        if (dut_out() !== m_out() || sdOP !== 3'd1 || sdLSA !== 21'h00ABCD) begin
            errors++; $display("FAIL single_hold: got %h expected %h", dut_out(), m_out());
        end
        rpSDREQ = 8'h04; sdACK = 1'b1;
        tick(); sdACK = 1'b0; #2;
        checks++;
        if (rpSDACK !== 8'h04) begin
            errors++; $display("FAIL single_ack: got %h expected %h", rpSDACK, 8'h04);
        end
        tick(); #2;
        checks++;
        if (rpSDACK !== 8'h00 || arbBUSY !== 1'b1) begin
            errors++; $display("FAIL single_ack_once: got %h/%b expected 00/1", rpSDACK, arbBUSY);
        end
        rpSDREQ = 8'h00;
        tick(); #2;
        checks++;
        if (arbBUSY !== 1'b0 || dut_out() !== m_out()) begin
            errors++; $display("FAIL single_idle: got %h expected %h", dut_out(), m_out());
        end
    endtask

    task automatic test_fairness();
        int guard = 0;
        do_reset();
        grants.delete();
        while (grants.size() < 9 && guard < 300) begin
            rpSDREQ = 8'hFF;
            if (m_ph == 3) rpSDREQ[m_scan] = 1'b0;
            sdACK = (m_ph == 1) && ($urandom_range(1) == 1);
            #2;
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL fair_cycle: got %h expected %h", dut_out(), m_out());
            end
            tick();
            guard++;
        end
        checks++;
        if (grants.size() < 9) begin
            errors++; $display("FAIL fair_budget: got %0d grants expected 9", grants.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (grants[i] != i % 8) begin
                    errors++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, grants[i], i % 8);
                end
            end
        end
        sdACK = 1'b0; rpSDREQ = '0;
    endtask

    task automatic test_wrap();
        logic [7:0] req = 8'h40;
        logic loaded = 1'b0;
        int guard = 0;
        do_reset();
        grants.delete();
        while (!(grants.size() == 3 && m_ph == 0) && guard < 100) begin
            if (m_ph == 3) req[m_scan] = 1'b0;
            if (grants.size() == 1 && m_ph == 0 && !loaded) begin
                req = 8'h41; loaded = 1'b1;
            end
            rpSDREQ = req;
            sdACK = (m_ph == 1);
            #2;
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL wrap_cycle: got %h expected %h", dut_out(), m_out());
            end
            tick();
            guard++;
        end
        checks++;
        if (grants.size() != 3 || grants[1] != 0 || grants[2] != 6) begin
            errors++; $display("FAIL wrap_order: got %0d grants [%0d %0d] expected [0 6]",
                               grants.size(), grants.size() > 1 ? grants[1] : -1,
                               grants.size() > 2 ? grants[2] : -1);
        end
        sdACK = 1'b0; rpSDREQ = '0;
    endtask

    task automatic test_timeout();
        int x, to_at = 0, ack_at = 0, to_n = 0, ack_n = 0;
        logic [7:0] ack_v = '0;
        do_reset();
        x = $urandom_range(7);
        rpSDREQ = 8'(1 << x);
        tick();
        for (int n = 1; n <= 40; n++) begin
            #2;
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL timeout_cycle: got %h expected %h", dut_out(), m_out());
            end
            if (arbTO === 1'b1) begin to_at = n; to_n++; end
            if (rpSDACK !== 8'h00) begin ack_at = n; ack_n++; ack_v = rpSDACK; end
            tick();
        end
        checks++;
        if (to_at != 16 || to_n != 1) begin
            errors++; $display("FAIL timeout_pulse: got cycle %0d count %0d expected cycle 16 count 1", to_at, to_n);
        end
        checks++;
        if (ack_at != 17 || ack_n != 1 || ack_v !== 8'(1 << x)) begin
            errors++; $display("FAIL timeout_ack: got cycle %0d count %0d val %h expected 17 1 %h",
                               ack_at, ack_n, ack_v, 8'(1 << x));
        end
        rpSDREQ = '0;
        tick();
        rpSDREQ = 8'(1 << x);
        tick();
        for (int n = 1; n < 16; n++) tick();
        sdACK = 1'b1;
        #2;
        checks++;
        if (arbTO !== 1'b0 || dut_out() !== m_out()) begin
            errors++; $display("FAIL timeout_ack_wins: got %h expected %h", dut_out(), m_out());
        end
        tick(); sdACK = 1'b0; #2;
        checks++;
        if (rpSDACK !== 8'(1 << x)) begin
            errors++; $display("FAIL timeout_ack_wins_ack: got %h expected %h", rpSDACK, 8'(1 << x));
        end
        rpSDREQ = '0;
    endtask

    task automatic test_clr();
        do_reset();
        rpSDREQ = 8'h01;
        tick();
        sdACK = 1'b1; clr = 1'b1;
        tick(); sdACK = 1'b0; #2;
        checks++;
        if (sdREQ !== 1'b0 || rpSDACK !== 8'h00 || arbBUSY !== 1'b0) begin
            errors++; $display("FAIL clr_idle: got %b %h %b expected 0 00 0", sdREQ, rpSDACK, arbBUSY);
        end
        tick(); #2;
        checks++;
        if (sdREQ !== 1'b0 || dut_out() !== m_out()) begin
            errors++; $display("FAIL clr_nogrant: got %h expected %h", dut_out(), m_out());
        end
        clr = 1'b0;
        tick(); #2;
        checks++;
        if (sdREQ !== 1'b1 || sdSCAN !== 3'd0) begin
            errors++; $display("FAIL clr_regrant: got %b/%0d expected 1/0", sdREQ, sdSCAN);
        end
        rpSDREQ = '0;
    endtask

    task automatic test_held();
        do_reset();
        rpSDREQ = 8'h08;
        tick();
        sdACK = 1'b1;
        tick();
        sdACK = 1'b0; rpSDREQ = 8'hFF;
        tick();
        for (int i = 0; i < 6; i++) begin
            sdACK = 1'($urandom);
            #2;
            checks++;
            if (sdREQ !== 1'b0 || arbBUSY !== 1'b1 || sdSCAN !== 3'd3 || dut_out() !== m_out()) begin
                errors++; $display("FAIL held_drop: got %h expected %h", dut_out(), m_out());
            end
            tick();
        end
        sdACK = 1'b0; rpSDREQ = 8'hF7;
        tick(); tick(); #2;
        checks++;
        if (sdREQ !== 1'b1 || sdSCAN !== 3'd4) begin
            errors++; $display("FAIL held_next: got %b/%0d expected 1/4", sdREQ, sdSCAN);
        end
        rpSDREQ = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rpSDREQ = 8'($urandom_range(255, 1));
        tick();
        rst = 1'b0; sdACK = 1'b1;
        tick();
        rst = 1'b1; sdACK = 1'b0; rpSDREQ = '0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (rpSDACK !== 8'h00 || dut_out() !== m_out()) begin
                errors++; $display("FAIL reset_mid: got %h expected %h", dut_out(), m_out());
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rpSDREQ = ($urandom_range(3) == 0) ? 8'($urandom) : (rpSDREQ & 8'($urandom));
            sdACK = ($urandom_range(3) == 0);
            clr = ($urandom_range(40) == 0);
            rst = ($urandom_range(150) != 0);
            rand_slices();
            #2;
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_out(), m_out());
            end
            tick();
        end
        rst = 1'b1; clr = 1'b0; sdACK = 1'b0; rpSDREQ = '0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; rpSDREQ = '0; sdACK = 1'b0;
        rpSDOPV = '0; rpSDLSAV = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_clr();
        test_held();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
